// File: rtl/spi_frame_dispatcher_pkg.sv
// Shared types for the SPI frame dispatcher: command codes, the draw-queue
// entry layout, FSM state encoding and the status byte packing helper.
package spi_frame_dispatcher_pkg;

  typedef enum logic [7:0] {
    CMD_DRAW         = 8'h01,
    CMD_SPRITE_WRITE = 8'h02,
    CMD_STATUS_READ  = 8'h03,
    CMD_QUEUE_CLEAR  = 8'h04
  } cmd_e;

  // Field order matches the byte order on the wire (id first, MSB side).
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } draw_entry_t;

  localparam int DRAW_ENTRY_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CMD          = 3'd1,
    ST_HDR          = 3'd2,
    ST_PAYLOAD_DRAW = 3'd3,
    ST_PAYLOAD_WR   = 3'd4,
    ST_STATUS       = 3'd5,
    ST_DISCARD      = 3'd6
  } state_e;

  function automatic logic [7:0] status_byte(input logic ovf, input logic err,
                                             input logic full, input logic empty,
                                             input logic [3:0] cnt);
    return {ovf, err, full, empty, cnt};
  endfunction

endpackage

// File: rtl/spi_frame_dispatcher_byte_rx.sv
// SPI mode-0 byte engine running entirely in the system clock domain.
// Ports:
//   clock, reset            system clock, async active-high reset
//   spi_sck/cs_n/mosi       raw SPI pins (synchronised here)
//   tx_load, tx_data        load a byte to be shifted out on MISO
//   spi_miso                MISO, 0 unless a loaded byte is in flight
//   byte_valid, rx_byte     one-clock pulse with the received byte
//   cs_start, cs_end        one-clock pulses on CS falling / rising
module spi_frame_dispatcher_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       spi_miso,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       cs_start,
  output logic       cs_end
);

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_prev_q, cs_prev_q;
  logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, active;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, rx_byte_q, tx_q;
  logic byte_valid_q, miso_en_q;

  // CS synchroniser resets to "selected": if reset releases in the middle of a
  // frame no false falling edge is seen, so the next frame starts only on a
  // genuine CS falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_start = ~cs_s & cs_prev_q;
  assign cs_end   = cs_s & ~cs_prev_q;
  assign active   = ~cs_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (!active) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[6:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_q    <= {shift_q[6:0], mosi_s};
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  // TX shifts only on falling edges inside a byte; the falling edge that
  // follows the 8th rising edge is skipped so a load issued around the byte
  // boundary always presents its MSB for the next byte's first rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_q      <= '0;
      miso_en_q <= 1'b0;
    end else if (tx_load) begin
      tx_q      <= tx_data;
      miso_en_q <= 1'b1;
    end else if (byte_valid_q || !active) begin
      miso_en_q <= 1'b0;
    end else if (sck_fall && bit_cnt_q != 3'd0) begin
      tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  assign spi_miso   = miso_en_q & tx_q[7];
  assign byte_valid = byte_valid_q;
  assign rx_byte    = rx_byte_q;

endmodule

// File: rtl/spi_frame_dispatcher.sv
// SPI slave front-end: decodes framed commands and routes them to the sprite
// storage write port, an internal draw-queue FIFO, or a MISO status byte.
// Ports:
//   clock, reset                       system clock, async active-high reset
//   spi_sck/cs_n/mosi, spi_miso        SPI mode-0 slave pins
//   sprite_w_select/en/addr/data       sprite storage write port (1-clk strobe)
//   dequeue, is_empty                  draw queue pop / empty flag
//   sprite_id/x/y/scale                queue head fields (0 when empty)
//   overflow, cmd_error                sticky error flags
//   dbg_state                          current command FSM state (state_e)
module spi_frame_dispatcher
  import spi_frame_dispatcher_pkg::*;
#(
  parameter int SPRITE_NUM    = 16,
  parameter int SPRITE_ADDR_W = 12,
  parameter int QUEUE_DEPTH   = 64,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          spi_sck,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic [$clog2(SPRITE_NUM)-1:0] sprite_w_select,
  output logic                          sprite_w_en,
  output logic [SPRITE_ADDR_W-1:0]      sprite_w_addr,
  output logic [7:0]                    sprite_w_data,
  input  logic                          dequeue,
  output logic                          is_empty,
  output logic [7:0]                    sprite_id,
  output logic [15:0]                   sprite_x,
  output logic [15:0]                   sprite_y,
  output logic [7:0]                    sprite_scale,
  output logic                          overflow,
  output logic                          cmd_error,
  output logic [2:0]                    dbg_state
);

  localparam int SEL_W = $clog2(SPRITE_NUM);
  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [2:0] LAST_IDX = 3'(DRAW_ENTRY_BYTES - 1);

  logic byte_valid, cs_start, cs_end, tx_load;
  logic [7:0] rx_byte, tx_data;

  spi_frame_dispatcher_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .tx_load(tx_load), .tx_data(tx_data), .spi_miso(spi_miso),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .cs_start(cs_start), .cs_end(cs_end)
  );

  state_e state_q, state_d;
  logic [2:0] idx_q;
  logic [39:0] entry_q;
  logic [7:0] sel_q, hi_q;
  logic [SPRITE_ADDR_W-1:0] addr_q;
  logic [15:0] hdr_word;
  logic unused_hdr;
  logic sel_ok;
  logic w_en_q;
  logic [SEL_W-1:0] w_sel_q;
  logic [SPRITE_ADDR_W-1:0] w_addr_q;
  logic [7:0] w_data_q;
  draw_entry_t mem_q [QUEUE_DEPTH];
  draw_entry_t push_entry, head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0] count_wide;
  logic [3:0] status_cnt;
  logic full, empty, do_push, do_pop;
  logic overflow_q, cmd_error_q;
  logic push_req, clear_req, err_set, wr_req, status_done;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; CS edges override everything else.
  always_comb begin
    state_d = state_q;
    if (cs_start) begin
      state_d = ST_CMD;
    end else if (cs_end) begin
      state_d = ST_IDLE;
    end else if (byte_valid) begin
      case (state_q)
        ST_CMD: begin
          case (rx_byte)
            CMD_DRAW:         state_d = ST_PAYLOAD_DRAW;
            CMD_SPRITE_WRITE: state_d = ST_HDR;
            CMD_STATUS_READ:  state_d = ST_STATUS;
            default:          state_d = ST_DISCARD;
          endcase
        end
        ST_HDR:    if (idx_q == 3'd2) state_d = ST_PAYLOAD_WR;
        ST_STATUS: state_d = ST_DISCARD;
        default:   state_d = state_q;
      endcase
    end
  end

  // Output decode: per-byte action strobes.
  always_comb begin
    push_req    = 1'b0;
    clear_req   = 1'b0;
    err_set     = 1'b0;
    tx_load     = 1'b0;
    wr_req      = 1'b0;
    status_done = 1'b0;
    if (byte_valid) begin
      case (state_q)
        ST_CMD: begin
          clear_req = (rx_byte == CMD_QUEUE_CLEAR);
          tx_load   = (rx_byte == CMD_STATUS_READ);
          err_set   = !(rx_byte inside {CMD_DRAW, CMD_SPRITE_WRITE, CMD_STATUS_READ,
                                        CMD_QUEUE_CLEAR});
        end
        ST_PAYLOAD_DRAW: push_req    = (idx_q == LAST_IDX);
        ST_PAYLOAD_WR:   wr_req      = 1'b1;
        ST_STATUS:       status_done = 1'b1;
        default: ;
      endcase
    end
  end

  assign hdr_word   = {hi_q, rx_byte};
  assign unused_hdr = ^hdr_word;
  assign sel_ok     = (32'(sel_q) < 32'(SPRITE_NUM));

  // Header / entry assembly and sprite write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      entry_q  <= '0;
      sel_q    <= '0;
      hi_q     <= '0;
      addr_q   <= '0;
      w_en_q   <= 1'b0;
      w_sel_q  <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_en_q <= wr_req & sel_ok;
      if (cs_start) begin
        idx_q <= '0;
      end else if (byte_valid && state_q == ST_HDR) begin
        idx_q <= (idx_q == 3'd2) ? 3'd0 : idx_q + 3'd1;
        case (idx_q)
          3'd0:    sel_q  <= rx_byte;
          3'd1:    hi_q   <= rx_byte;
          default: addr_q <= hdr_word[SPRITE_ADDR_W-1:0];
        endcase
      end else if (byte_valid && state_q == ST_PAYLOAD_DRAW) begin
        idx_q   <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        entry_q <= {entry_q[31:0], rx_byte};
      end
      if (wr_req) begin
        w_sel_q  <= sel_q[SEL_W-1:0];
        w_addr_q <= addr_q;
        w_data_q <= rx_byte;
        addr_q   <= addr_q + SPRITE_ADDR_W'(1);
      end
    end
  end

  // Draw queue. Clear beats push; a push into a full queue survives only when
  // a dequeue frees a slot on the same clock.
  assign push_entry = {entry_q, rx_byte};
  assign full       = (count_q == CW'(QUEUE_DEPTH));
  assign empty      = (count_q == '0);
  assign do_pop     = dequeue & ~empty & ~clear_req;
  assign do_push    = push_req & (~full | dequeue) & ~clear_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_req) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  // Sticky flags; the status byte snapshot is taken at load, so clearing at
  // the end of the status byte cannot hide a flag from the reader.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      cmd_error_q <= 1'b0;
    end else if (status_done) begin
      overflow_q  <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      if (push_req && full && !dequeue) overflow_q <= 1'b1;
      if (err_set) cmd_error_q <= 1'b1;
    end
  end

  assign count_wide = 32'(count_q);
  assign status_cnt = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];
  assign tx_data    = status_byte(overflow_q, cmd_error_q, full, empty, status_cnt);

  assign head            = mem_q[rd_ptr_q];
  assign is_empty        = empty;
  assign sprite_id       = empty ? '0 : head.id;
  assign sprite_x        = empty ? '0 : head.x;
  assign sprite_y        = empty ? '0 : head.y;
  assign sprite_scale    = empty ? '0 : head.scale;
  assign sprite_w_en     = w_en_q;
  assign sprite_w_select = w_sel_q;
  assign sprite_w_addr   = w_addr_q;
  assign sprite_w_data   = w_data_q;
  assign overflow        = overflow_q;
  assign cmd_error       = cmd_error_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_spi_frame_dispatcher.sv
// Bench for spi_frame_dispatcher: SPI master driver tasks, a scoreboard for
// sprite write strobes, a table of sprite-write vectors and hand-written
// sequences for queue, status and reset corner cases.
module tb_spi_frame_dispatcher;

  localparam int SPRITE_NUM    = 16;
  localparam int SPRITE_ADDR_W = 8;
  localparam int QUEUE_DEPTH   = 64;
  localparam int SYNC_STAGES   = 2;
  localparam int HALF          = 5;

  logic clock = 1'b0;
  logic reset, spi_sck, spi_cs_n, spi_mosi, spi_miso, dequeue;
  logic [3:0] sprite_w_select;
  logic sprite_w_en, is_empty, overflow, cmd_error;
  logic [7:0] sprite_w_addr, sprite_w_data, sprite_id, sprite_scale;
  logic [15:0] sprite_x, sprite_y;
  logic [2:0] dbg_state;

  always #5 clock = ~clock;

  spi_frame_dispatcher #(
    .SPRITE_NUM(SPRITE_NUM), .SPRITE_ADDR_W(SPRITE_ADDR_W),
    .QUEUE_DEPTH(QUEUE_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .sprite_w_select(sprite_w_select),
    .sprite_w_en(sprite_w_en), .sprite_w_addr(sprite_w_addr),
    .sprite_w_data(sprite_w_data), .dequeue(dequeue), .is_empty(is_empty),
    .sprite_id(sprite_id), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_scale(sprite_scale), .overflow(overflow), .cmd_error(cmd_error),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int exp_strobes = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_v;
  logic [7:0] frame_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] sel, hi, lo, data;
    logic       exp_en;
    logic [7:0] exp_addr;
  } wr_vec_t;
  wr_vec_t wr_tab[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && sprite_w_en) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got sel=%0h addr=%0h data=%0h required none",
                 sprite_w_select, sprite_w_addr, sprite_w_data);
      end else begin
        exp_v = exp_q.pop_front();
        check("sprite_write", {44'b0, sprite_w_select, sprite_w_addr, sprite_w_data},
              {44'b0, exp_v});
      end
    end
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      spi_mosi = tx[b];
      wait_clk(HALF);
      rx[b] = spi_miso;
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame();
    logic [7:0] r;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    rx_q.delete();
    foreach (frame_q[i]) begin
      xfer(frame_q[i], r);
      rx_q.push_back(r);
    end
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic deq_pulse();
    dequeue = 1'b1;
    @(posedge clock);
    #1;
    dequeue = 1'b0;
  endtask

  // One-entry DRAW frame; with deq set, dequeue is held for exactly the
  // clock on which the entry is pushed.
  task automatic draw_one(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] sc, input logic deq);
    logic [7:0] b[7];
    logic [7:0] r;
    int n;
    b = '{8'h01, id, x[15:8], x[7:0], y[15:8], y[7:0], sc};
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 6; i++) xfer(b[i], r);
    if (!deq) begin
      xfer(b[6], r);
    end else begin
      fork
        xfer(b[6], r);
        begin
          n = 0;
          while (!dut.byte_valid && n < 400) begin
            @(negedge clock);
            n++;
          end
          check("deq_sync_timeout", 64'(n >= 400), 64'd0);
          if (n < 400) begin
            dequeue = 1'b1;
            @(posedge clock);
            #1;
            dequeue = 1'b0;
          end
        end
      join
    end
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic status_read(input logic [7:0] exp, input string name);
    frame_q.delete();
    frame_q.push_back(8'h03);
    frame_q.push_back(8'h00);
    send_frame();
    check({name, "_cmd_miso"}, 64'(rx_q[0]), 64'h00);
    check(name, 64'(rx_q[1]), 64'(exp));
  endtask

  initial begin
    logic [7:0] r;
    wr_tab[0] = '{sel: 8'h00, hi: 8'h00, lo: 8'h10, data: 8'h5A, exp_en: 1'b1, exp_addr: 8'h10};
    wr_tab[1] = '{sel: 8'h0F, hi: 8'h12, lo: 8'h34, data: 8'hC3, exp_en: 1'b1, exp_addr: 8'h34};
    wr_tab[2] = '{sel: 8'h10, hi: 8'h00, lo: 8'h20, data: 8'h11, exp_en: 1'b0, exp_addr: 8'h00};
    wr_tab[3] = '{sel: 8'hFF, hi: 8'h00, lo: 8'h30, data: 8'h22, exp_en: 1'b0, exp_addr: 8'h00};
    wr_tab[4] = '{sel: 8'h07, hi: 8'h00, lo: 8'hFE, data: 8'h99, exp_en: 1'b1, exp_addr: 8'hFE};

    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; dequeue = 1'b0;
    wait_clk(3);
    check("rst_is_empty", 64'(is_empty), 64'd1);
    check("rst_w_en", 64'(sprite_w_en), 64'd0);
    reset = 1'b0;
    wait_clk(4);
    check("idle_is_empty", 64'(is_empty), 64'd1);
    check("idle_data", {sprite_id, sprite_x, sprite_y, sprite_scale}, 64'd0);
    check("idle_w_port", {44'b0, sprite_w_select, sprite_w_addr, sprite_w_data}, 64'd0);
    check("idle_flags", {62'b0, overflow, cmd_error}, 64'd0);
    check("idle_miso", 64'(spi_miso), 64'd0);
    check("idle_state", 64'(dbg_state), 64'd0);

    // Sprite-write table.
    foreach (wr_tab[i]) begin
      if (wr_tab[i].exp_en) begin
        exp_q.push_back({wr_tab[i].sel[3:0], wr_tab[i].exp_addr, wr_tab[i].data});
        exp_strobes++;
      end
      frame_q.delete();
      frame_q.push_back(8'h02);
      frame_q.push_back(wr_tab[i].sel);
      frame_q.push_back(wr_tab[i].hi);
      frame_q.push_back(wr_tab[i].lo);
      frame_q.push_back(wr_tab[i].data);
      send_frame();
    end

    // Address wrap 0xFF -> 0x00.
    exp_q.push_back({4'h3, 8'hFF, 8'hAA});
    exp_q.push_back({4'h3, 8'h00, 8'hBB});
    exp_strobes += 2;
    frame_q.delete();
    frame_q.push_back(8'h02); frame_q.push_back(8'h03); frame_q.push_back(8'h00);
    frame_q.push_back(8'hFF); frame_q.push_back(8'hAA); frame_q.push_back(8'hBB);
    send_frame();

    // Single DRAW entry, then dequeue.
    draw_one(8'h07, 16'h0100, 16'h0080, 8'h02, 1'b0);
    check("draw_not_empty", 64'(is_empty), 64'd0);
    check("draw_head", {sprite_id, sprite_x, sprite_y, sprite_scale},
          {16'b0, 8'h07, 16'h0100, 16'h0080, 8'h02});
    deq_pulse();
    check("deq_empty", 64'(is_empty), 64'd1);
    check("deq_head_zero", 64'(sprite_id), 64'd0);
    deq_pulse();
    check("deq_on_empty", 64'(is_empty), 64'd1);
    // Push with coincident dequeue into an empty queue: entry stays.
    draw_one(8'h21, 16'h0A0B, 16'h0C0D, 8'h0E, 1'b1);
    check("push_deq_empty", 64'(is_empty), 64'd0);
    check("push_deq_empty_head", {sprite_id, sprite_x, sprite_y, sprite_scale},
          {16'b0, 8'h21, 16'h0A0B, 16'h0C0D, 8'h0E});
    deq_pulse();
    check("push_deq_empty_pop", 64'(is_empty), 64'd1);

    // QUEUE_DEPTH+1 entries: last one dropped.
    frame_q.delete();
    frame_q.push_back(8'h01);
    for (int i = 0; i <= QUEUE_DEPTH; i++) begin
      frame_q.push_back(8'(i));
      frame_q.push_back(8'h10); frame_q.push_back(8'(i));
      frame_q.push_back(8'h02); frame_q.push_back(8'(i));
      frame_q.push_back(8'(i) ^ 8'h5A);
    end
    send_frame();
    check("ovf_set", 64'(overflow), 64'd1);
    check("full_head", {sprite_id, sprite_x, sprite_y, sprite_scale},
          {16'b0, 8'h00, 16'h1000, 16'h0200, 8'h5A});
    status_read(8'hAF, "status_full");
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Push + dequeue on a full queue: both succeed.
    draw_one(8'hC8, 16'h1234, 16'h5678, 8'h9A, 1'b1);
    check("full_push_deq_ovf", 64'(overflow), 64'd0);
    check("full_push_deq_head", 64'(sprite_id), 64'd1);
    status_read(8'h2F, "status_still_full");
    for (int i = 1; i < QUEUE_DEPTH; i++) begin
      check("drain_id", 64'(sprite_id), 64'(i));
      deq_pulse();
    end
    check("drain_tail", {sprite_id, sprite_x, sprite_y, sprite_scale},
          {16'b0, 8'hC8, 16'h1234, 16'h5678, 8'h9A});
    deq_pulse();
    check("drain_empty", 64'(is_empty), 64'd1);

    // QUEUE_CLEAR.
    draw_one(8'h31, 16'h0001, 16'h0002, 8'h03, 1'b0);
    draw_one(8'h32, 16'h0004, 16'h0005, 8'h06, 1'b0);
    check("pre_clear", 64'(is_empty), 64'd0);
    frame_q.delete();
    frame_q.push_back(8'h04);
    send_frame();
    check("clear_empty", 64'(is_empty), 64'd1);
    check("clear_head", 64'(sprite_id), 64'd0);
    status_read(8'h10, "status_empty");

    // CS raised mid-entry: only the complete entry is queued.
    frame_q.delete();
    frame_q.push_back(8'h01);
    frame_q.push_back(8'h51); frame_q.push_back(8'h00); frame_q.push_back(8'h11);
    frame_q.push_back(8'h00); frame_q.push_back(8'h22); frame_q.push_back(8'h33);
    frame_q.push_back(8'h52); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    frame_q.push_back(8'h00);
    send_frame();
    check("partial_one_entry", {sprite_id, sprite_x, sprite_y, sprite_scale},
          {16'b0, 8'h51, 16'h0011, 16'h0022, 8'h33});
    deq_pulse();
    check("partial_dropped", 64'(is_empty), 64'd1);

    // Unknown command.
    frame_q.delete();
    frame_q.push_back(8'h55); frame_q.push_back(8'h12); frame_q.push_back(8'h34);
    send_frame();
    check("cmd_error_set", 64'(cmd_error), 64'd1);
    check("cmd_error_no_queue", 64'(is_empty), 64'd1);

    // Reset in the middle of a frame.
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    xfer(8'h01, r); xfer(8'h40, r); xfer(8'h00, r);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    check("midrst_cmd_error", 64'(cmd_error), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    xfer(8'h01, r); xfer(8'h41, r); xfer(8'h00, r); xfer(8'h00, r);
    xfer(8'h00, r); xfer(8'h00, r); xfer(8'h00, r);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(12);
    check("midrst_no_entry", 64'(is_empty), 64'd1);
    draw_one(8'h42, 16'h0707, 16'h0808, 8'h09, 1'b0);
    check("after_rst_frame", 64'(sprite_id), 64'h42);

    check("sb_queue_drained", 64'(exp_q.size()), 64'd0);
    check("strobe_count", 64'(strobes), 64'(exp_strobes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
